mdio_arb: RTL and testbench
===========================

MDIO_ARB -- requirements
Module: mdio_arb

Interface
REQ-001 SHALL have parameter START_WAIT, default 15: max cycles from request pulse to mdio_ready low.
REQ-002 SHALL have parameter TIMEOUT, default 4095: max cycles with mdio_ready low before abort; counter width 12 bits.
REQ-003 SHALL have port clock  in  1  single system clock (2.5 MHz MDIO domain); all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have ports a_req / b_req  in  1  level transaction request, port A (PHY poller) / port B (host).
REQ-006 SHALL have ports a_wr / b_wr  in  1  1=write, 0=read.
REQ-007 SHALL have ports a_addr / b_addr  in  5  PHY register address.
REQ-008 SHALL have ports a_wdata / b_wdata  in  16  write data.
REQ-009 SHALL have ports a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports a_err / b_err  out  1  completion status, valid with ack, held until next ack.
REQ-011 SHALL have ports a_rdata / b_rdata  out  16  read result, updated only with ack.
REQ-012 SHALL have port mdio_addr  out  5  register address to MDIO engine.
REQ-013 SHALL have port mdio_wr_data  out  16  write data to engine.
REQ-014 SHALL have ports mdio_rd_request / mdio_wr_request  out  1  one-cycle start pulses to engine.
REQ-015 SHALL have port mdio_ready  in  1  engine idle; falls while busy, rises at completion.
REQ-016 SHALL have port mdio_rd_data  in  16  engine read data, valid when mdio_ready high after read.
REQ-017 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
REQ-019 IDLE SHALL grant only when mdio_ready=1 and a_req|b_req; otherwise remain IDLE.
REQ-020 Single requester SHALL be granted; both requesting SHALL grant the port not granted last (round-robin); last_grant resets to B so A wins first tie.
REQ-021 On grant, addr, wr, wdata of granted port SHALL be latched; mdio_addr/mdio_wr_data SHALL drive latched values until next grant.
REQ-022 ISSUE (cycle after grant) SHALL assert exactly one of mdio_rd_request/mdio_wr_request for exactly one cycle, per latched wr, then enter WAIT_START with counter cleared.
REQ-023 WAIT_START SHALL move to WAIT_DONE on mdio_ready=0; after START_WAIT cycles without it SHALL enter DONE with error set.
REQ-024 WAIT_DONE SHALL move to DONE on mdio_ready=1, capturing mdio_rd_data that cycle; after TIMEOUT cycles still low SHALL enter DONE with error set.
REQ-025 DONE SHALL pulse granted port's ack for one cycle, set its err, load its rdata (read ok: captured data; write ok: 16'h0000; error: 16'hFFFF), then return IDLE.
REQ-026 Ungranted port's ack, err, rdata SHALL be unchanged during another port's transaction.
REQ-027 Nominal latency: grant T, request pulse T+1, ack in cycle after mdio_ready returns high.
REQ-028 Requester SHALL hold req and fields until ack; req still high in cycle after ack SHALL be treated as a new request.
REQ-029 req dropped before ack SHALL not abort; transaction completes and ack still pulses.
REQ-030 Request pulses SHALL never be asserted outside ISSUE; at most one transaction outstanding.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, last_grant=B, all ack/err/request outputs 0, busy 0, a_rdata/b_rdata 16'h0000, mdio_addr 0, mdio_wr_data 0 at next edge.
REQ-032 rst mid-transaction SHALL drop the transaction without ack; the next grant SHALL wait for mdio_ready=1.

Verification
REQ-033 A read addr 5'h1f, engine busy 40 cycles returning 16'h0060 -> one mdio_rd_request pulse, mdio_addr=5'h1f, a_ack one cycle after ready rises, a_rdata=16'h0060, a_err=0.
REQ-034 A and B request same cycle from reset, then both again -> A served first, then B; next tie grants A; no overlapping request pulses.
REQ-035 B write addr 5'h09 data 16'h0200 -> mdio_wr_request pulse with mdio_wr_data=16'h0200, b_ack, b_rdata=16'h0000, a outputs unchanged.
REQ-036 Engine never drops ready -> b_ack after 15 WAIT_START cycles, b_err=1, b_rdata=16'hFFFF; engine stuck low -> ack after 4095 cycles with err=1.
REQ-037 rst during WAIT_DONE with ready still low -> no ack, busy=0 next cycle; pending a_req not granted until mdio_ready=1.

Source files
------------

// File: rtl/mdio_arb.sv
// mdio_arb: round-robin arbiter sharing one MDIO engine between a PHY poller (A) and a host (B).
module mdio_arb #(
  parameter int START_WAIT = 15,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_wr,
  input  logic        b_wr,
  input  logic [4:0]  a_addr,
  input  logic [4:0]  b_addr,
  input  logic [15:0] a_wdata,
  input  logic [15:0] b_wdata,
  output logic        a_ack,
  output logic        b_ack,
  output logic        a_err,
  output logic        b_err,
  output logic [15:0] a_rdata,
  output logic [15:0] b_rdata,
  output logic [4:0]  mdio_addr,
  output logic [15:0] mdio_wr_data,
  output logic        mdio_rd_request,
  output logic        mdio_wr_request,
  input  logic        mdio_ready,
  input  logic [15:0] mdio_rd_data,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE} state_t;
  state_t      r_state;
  logic [11:0] r_cnt;
  logic        r_last_b;
  logic        r_sel_b;
  logic        r_wr;
  logic        w_grant_b;
  logic        w_fin_ok;
  logic        w_fin_err;
  logic [15:0] w_fin_data;
  // B wins only when alone or when A was served last
  assign w_grant_b  = b_req && (!a_req || !r_last_b);
  assign w_fin_ok   = r_state == WAIT_DONE && mdio_ready;
  assign w_fin_err  = (r_state == WAIT_START && mdio_ready && r_cnt == 12'(START_WAIT - 1)) ||
                      (r_state == WAIT_DONE && !mdio_ready && r_cnt == 12'(TIMEOUT - 1));
  assign w_fin_data = w_fin_err ? 16'hFFFF : (r_wr ? 16'h0000 : mdio_rd_data);
  assign busy       = r_state != IDLE;
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_last_b        <= 1'b1;
      r_sel_b         <= 1'b0;
      r_wr            <= 1'b0;
      a_ack           <= 1'b0;
      b_ack           <= 1'b0;
      a_err           <= 1'b0;
      b_err           <= 1'b0;
      a_rdata         <= '0;
      b_rdata         <= '0;
      mdio_addr       <= '0;
      mdio_wr_data    <= '0;
      mdio_rd_request <= 1'b0;
      mdio_wr_request <= 1'b0;
    end else begin
      a_ack           <= 1'b0;
      b_ack           <= 1'b0;
      mdio_rd_request <= 1'b0;
      mdio_wr_request <= 1'b0;
      case (r_state)
        IDLE: if (mdio_ready && (a_req || b_req)) begin
          r_sel_b         <= w_grant_b;
          r_last_b        <= w_grant_b;
          r_wr            <= w_grant_b ? b_wr : a_wr;
          mdio_addr       <= w_grant_b ? b_addr : a_addr;
          mdio_wr_data    <= w_grant_b ? b_wdata : a_wdata;
          mdio_rd_request <= !(w_grant_b ? b_wr : a_wr);
          mdio_wr_request <= w_grant_b ? b_wr : a_wr;
          r_state         <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_START;
        end
        WAIT_START: begin
          r_cnt <= mdio_ready ? r_cnt + 12'd1 : '0;
          if (!mdio_ready) r_state <= WAIT_DONE;
        end
        WAIT_DONE: r_cnt <= r_cnt + 12'd1;
        default: r_state <= IDLE;
      endcase
      if (w_fin_ok || w_fin_err) begin
        r_state <= DONE;
        if (r_sel_b) begin
          b_ack   <= 1'b1;
          b_err   <= w_fin_err;
          b_rdata <= w_fin_data;
        end else begin
          a_ack   <= 1'b1;
          a_err   <= w_fin_err;
          a_rdata <= w_fin_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_arb.sv
// tb_mdio_arb: directed checks of arbitration, transaction flow, timeouts and reset for mdio_arb.
module tb_mdio_arb;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, a_err, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [4:0]  mdio_addr;
  logic [15:0] mdio_wr_data;
  logic        mdio_rd_request, mdio_wr_request;
  logic        mdio_ready = 1'b1;
  logic [15:0] mdio_rd_data = '0;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  mdio_arb dut (
    .clock(clock), .rst(rst),
    .a_req(a_req), .b_req(b_req), .a_wr(a_wr), .b_wr(b_wr),
    .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_err(a_err), .b_err(b_err),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mdio_addr(mdio_addr), .mdio_wr_data(mdio_wr_data),
    .mdio_rd_request(mdio_rd_request), .mdio_wr_request(mdio_wr_request),
    .mdio_ready(mdio_ready), .mdio_rd_data(mdio_rd_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge of the ISSUE cycle
  task automatic wait_req(input string tag);
    int n = 0;
    while (!(mdio_rd_request || mdio_wr_request) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 20), 1);
    chk({tag, "_one_pulse"}, 32'(mdio_rd_request && mdio_wr_request), 0);
  endtask

  // Engine busy for cyc cycles starting in ISSUE; leaves the bench in the ack cycle
  task automatic serve(input int cyc, input logic [15:0] data);
    mdio_ready = 1'b0;
    repeat (cyc - 1) tick();
    mdio_ready = 1'b1;
    mdio_rd_data = data;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_mdio_addr", 32'(mdio_addr), 0);
    chk("rst_rd_req", 32'(mdio_rd_request), 0);

    a_req = 1'b1; a_wr = 1'b0; a_addr = 5'h1f;
    tick();
    chk("a_rd_pulse", 32'(mdio_rd_request), 1);
    chk("a_rd_addr", 32'(mdio_addr), 32'h1f);
    chk("a_rd_busy", 32'(busy), 1);
    mdio_ready = 1'b0;
    tick();
    chk("a_rd_pulse_end", 32'(mdio_rd_request), 0);
    repeat (38) tick();
    chk("a_rd_no_early_ack", 32'(a_ack), 0);
    mdio_ready = 1'b1; mdio_rd_data = 16'h0060;
    tick();
    chk("a_rd_ack", 32'(a_ack), 1);
    chk("a_rd_rdata", 32'(a_rdata), 32'h0060);
    chk("a_rd_err", 32'(a_err), 0);
    a_req = 1'b0;
    tick();
    chk("a_rd_ack_one_cycle", 32'(a_ack), 0);
    chk("a_rd_idle", 32'(busy), 0);

    rst = 1'b1; tick(); rst = 1'b0;
    a_req = 1'b1; a_addr = 5'h01; b_req = 1'b1; b_wr = 1'b0; b_addr = 5'h02;
    wait_req("tie1_req");
    chk("tie1_grant_a", 32'(mdio_addr), 32'h01);
    serve(3, 16'h1111);
    chk("tie1_a_ack", 32'(a_ack), 1);
    chk("tie1_b_ack", 32'(b_ack), 0);
    chk("tie1_a_rdata", 32'(a_rdata), 32'h1111);
    a_req = 1'b0;
    wait_req("tie1_b_req");
    chk("tie1_grant_b", 32'(mdio_addr), 32'h02);
    serve(3, 16'h2222);
    chk("tie1_b_ack2", 32'(b_ack), 1);
    chk("tie1_b_rdata", 32'(b_rdata), 32'h2222);
    chk("tie1_a_kept", 32'(a_rdata), 32'h1111);
    a_req = 1'b1;
    wait_req("tie2_req");
    chk("tie2_grant_a", 32'(mdio_addr), 32'h01);
    serve(3, 16'h3333);
    chk("tie2_a_ack", 32'(a_ack), 1);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    b_req = 1'b1; b_wr = 1'b1; b_addr = 5'h09; b_wdata = 16'h0200;
    wait_req("bw_req");
    chk("bw_wr_pulse", 32'(mdio_wr_request), 1);
    chk("bw_wr_data", 32'(mdio_wr_data), 32'h0200);
    chk("bw_addr", 32'(mdio_addr), 32'h09);
    serve(5, 16'hdead);
    chk("bw_ack", 32'(b_ack), 1);
    chk("bw_rdata", 32'(b_rdata), 0);
    chk("bw_err", 32'(b_err), 0);
    chk("bw_a_ack", 32'(a_ack), 0);
    chk("bw_a_rdata", 32'(a_rdata), 32'h3333);
    b_req = 1'b0; b_wr = 1'b0;
    tick();

    b_req = 1'b1;
    wait_req("nostart_req");
    repeat (15) tick();
    chk("nostart_no_early_ack", 32'(b_ack), 0);
    tick();
    chk("nostart_ack", 32'(b_ack), 1);
    chk("nostart_err", 32'(b_err), 1);
    chk("nostart_rdata", 32'(b_rdata), 32'hFFFF);
    b_req = 1'b0;
    tick();

    a_req = 1'b1; a_addr = 5'h04;
    wait_req("stuck_req");
    mdio_ready = 1'b0;
    repeat (4096) tick();
    chk("stuck_no_early_ack", 32'(a_ack), 0);
    tick();
    chk("stuck_ack", 32'(a_ack), 1);
    chk("stuck_err", 32'(a_err), 1);
    chk("stuck_rdata", 32'(a_rdata), 32'hFFFF);
    chk("stuck_b_err_kept", 32'(b_err), 1);
    a_req = 1'b0; mdio_ready = 1'b1;
    tick();

    a_req = 1'b1; a_addr = 5'h03;
    wait_req("rstmid_req");
    mdio_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_ack", 32'(a_ack), 0);
    chk("rstmid_rdata", 32'(a_rdata), 0);
    repeat (3) tick();
    chk("rstmid_no_grant", 32'(busy), 0);
    mdio_ready = 1'b1;
    tick();
    chk("rstmid_grant", 32'(busy), 1);
    chk("rstmid_pulse", 32'(mdio_rd_request), 1);
    serve(3, 16'h4444);
    chk("rstmid_ack2", 32'(a_ack), 1);
    chk("rstmid_rdata2", 32'(a_rdata), 32'h4444);
    a_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
